// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: multi-cycle multiply/divide unit owning the architectural HI/LO pair.
// Multiplies complete after MUL_CYCLES cycles; divides take 32 restoring iterations plus
// one sign-fix cycle. busy stalls dependent HI/LO readers; done pulses on each write-back.
module hilo_muldiv_unit #(
  parameter int unsigned MUL_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  // Counter wide enough for both the multiply latency and the 32 divide iterations.
  localparam int unsigned CntW = ($clog2(MUL_CYCLES) > 5) ? $clog2(MUL_CYCLES) : 5;
  localparam logic [CntW-1:0] MulLoad = CntW'(MUL_CYCLES - 1);
  localparam logic [CntW-1:0] DivLoad = CntW'(31);

  localparam logic [2:0] OpMult  = 3'b000;
  localparam logic [2:0] OpMultu = 3'b001;
  localparam logic [2:0] OpDiv   = 3'b010;
  localparam logic [2:0] OpDivu  = 3'b011;
  localparam logic [2:0] OpMthi  = 3'b100;
  localparam logic [2:0] OpMtlo  = 3'b101;

  typedef enum logic [2:0] {StIdle, StMul, StDiv, StFix, StDivZero} state_e;

  state_e          state;
  logic [CntW-1:0] cnt_q;
  logic [31:0]     opa_q;      // multiplicand, or dividend for divide-by-zero
  logic [31:0]     opb_q;      // multiplier, or divisor magnitude
  logic            sgn_q;      // signed multiply
  logic [31:0]     rem_q;      // partial remainder
  logic [31:0]     dvd_q;      // dividend shifting out, quotient bits shifting in
  logic            neg_quo_q;
  logic            neg_rem_q;

  logic            accept;
  logic            op_signed;
  logic [31:0]     a_mag;
  logic [31:0]     b_mag;
  logic [63:0]     mul_a;
  logic [63:0]     mul_b;
  logic [63:0]     prod;
  logic [32:0]     rem_shift;
  logic [32:0]     rem_diff;
  logic [31:0]     rem_step;
  logic [31:0]     dvd_step;
  logic [31:0]     quo_fix;
  logic [31:0]     rem_fix;

  // Accept decode, operand magnitudes, product and one restoring-divide step.
  always_comb begin
    accept    = start && !busy && !flush;
    op_signed = (op == OpMult) || (op == OpDiv);
    a_mag     = (op_signed && a[31]) ? (~a + 32'd1) : a;
    b_mag     = (op_signed && b[31]) ? (~b + 32'd1) : b;

    // Sign-extended 64x64 product; the low 64 bits equal the 32x32 result.
    mul_a = {{32{sgn_q & opa_q[31]}}, opa_q};
    mul_b = {{32{sgn_q & opb_q[31]}}, opb_q};
    prod  = mul_a * mul_b;

    rem_shift = {rem_q, dvd_q[31]};
    rem_diff  = rem_shift - {1'b0, opb_q};
    rem_step  = rem_diff[32] ? rem_shift[31:0] : rem_diff[31:0];
    dvd_step  = {dvd_q[30:0], ~rem_diff[32]};

    quo_fix = neg_quo_q ? (~dvd_q + 32'd1) : dvd_q;
    rem_fix = neg_rem_q ? (~rem_q + 32'd1) : rem_q;
  end

  // Control FSM with registered busy/done and the HI/LO architectural state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= StIdle;
      busy      <= 1'b0;
      done      <= 1'b0;
      hi        <= '0;
      lo        <= '0;
      cnt_q     <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      sgn_q     <= 1'b0;
      rem_q     <= '0;
      dvd_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      done <= 1'b0;
      if (busy && flush) begin
        // Abort: HI/LO keep their old values.
        state <= StIdle;
        busy  <= 1'b0;
      end else begin
        case (state)
          StIdle: begin
            if (accept) begin
              case (op)
                OpMult, OpMultu: begin
                  opa_q <= a;
                  opb_q <= b;
                  sgn_q <= op_signed;
                  cnt_q <= MulLoad;
                  state <= StMul;
                  busy  <= 1'b1;
                end
                OpDiv, OpDivu: begin
                  busy <= 1'b1;
                  if (b == 32'd0) begin
                    opa_q <= a;
                    state <= StDivZero;
                  end else begin
                    rem_q     <= '0;
                    dvd_q     <= a_mag;
                    opb_q     <= b_mag;
                    neg_quo_q <= op_signed & (a[31] ^ b[31]);
                    neg_rem_q <= op_signed & a[31];
                    cnt_q     <= DivLoad;
                    state     <= StDiv;
                  end
                end
                OpMthi:  hi <= a;
                OpMtlo:  lo <= a;
                default: ;
              endcase
            end
          end
          StMul: begin
            if (cnt_q == '0) begin
              {hi, lo} <= prod;
              state    <= StIdle;
              busy     <= 1'b0;
              done     <= 1'b1;
            end else begin
              cnt_q <= cnt_q - CntW'(1);
            end
          end
          StDiv: begin
            rem_q <= rem_step;
            dvd_q <= dvd_step;
            if (cnt_q == '0) begin
              state <= StFix;
            end else begin
              cnt_q <= cnt_q - CntW'(1);
            end
          end
          StFix: begin
            hi    <= rem_fix;
            lo    <= quo_fix;
            state <= StIdle;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
          StDivZero: begin
            hi    <= opa_q;
            lo    <= 32'hFFFF_FFFF;
            state <= StIdle;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
          default: begin
            state <= StIdle;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Self-checking bench for hilo_muldiv_unit: directed vector table, hand-written corner
// sequences (flush, start-while-busy, back-to-back, reset mid-op) and random ops
// checked against an arithmetic reference model.
module tb_hilo_muldiv_unit;

  localparam int unsigned MulCycles = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  hilo_muldiv_unit #(
    .MUL_CYCLES(MulCycles)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .op   (op),
    .a    (a),
    .b    (b),
    .flush(flush),
    .busy (busy),
    .done (done),
    .hi   (hi),
    .lo   (lo)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
    string       name;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: plain 64-bit arithmetic on the architectural rules.
  function automatic void model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] eh, output logic [31:0] el,
                                output int lat);
    longint          sp;
    longint          sq;
    longint          sr;
    longint unsigned up;
    longint unsigned uq;
    longint unsigned ur;
    eh  = hi;
    el  = lo;
    lat = 0;
    case (o)
      3'd0: begin
        sp = longint'($signed(x)) * longint'($signed(y));
        {eh, el} = sp;
        lat = int'(MulCycles);
      end
      3'd1: begin
        up = {32'd0, x} * {32'd0, y};
        {eh, el} = up;
        lat = int'(MulCycles);
      end
      3'd2, 3'd3: begin
        if (y == 32'd0) begin
          eh  = x;
          el  = 32'hFFFF_FFFF;
          lat = 1;
        end else if (o == 3'd2) begin
          sq  = longint'($signed(x)) / longint'($signed(y));
          sr  = longint'($signed(x)) % longint'($signed(y));
          el  = sq[31:0];
          eh  = sr[31:0];
          lat = 33;
        end else begin
          uq  = {32'd0, x} / {32'd0, y};
          ur  = {32'd0, x} % {32'd0, y};
          el  = uq[31:0];
          eh  = ur[31:0];
          lat = 33;
        end
      end
      default: ;
    endcase
  endfunction

  // Present one start for a single edge, then scramble the operand inputs.
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    tick();
    start = 1'b0;
    op    = 3'($urandom_range(7));
    a     = $urandom;
    b     = $urandom;
  endtask

  // Issue a mult/div and wait (bounded) for done; returns in the done cycle.
  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] eh, input logic [31:0] el,
                        input int lat);
    logic [31:0] hi0;
    logic [31:0] lo0;
    bit          busy_ok;
    bit          old_ok;
    int          n;
    hi0     = hi;
    lo0     = lo;
    busy_ok = 1'b1;
    old_ok  = 1'b1;
    n       = 0;
    issue(o, x, y);
    while (!done && n < 60) begin
      if (lat > 1 && !busy) busy_ok = 1'b0;
      if (hi !== hi0 || lo !== lo0) old_ok = 1'b0;
      tick();
      n++;
    end
    chk({name, " latency"}, 64'(n), 64'(lat));
    chk({name, " hi"}, 64'(hi), 64'(eh));
    chk({name, " lo"}, 64'(lo), 64'(el));
    chk({name, " busy at done"}, 64'(busy), 64'(0));
    chk({name, " busy held"}, 64'(busy_ok), 64'(1));
    chk({name, " hilo held"}, 64'(old_ok), 64'(1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] eh;
    logic [31:0] el;
    int          lat;
    int          n;
    bit          seen;
    logic [2:0]  ro;
    logic [31:0] rx;
    logic [31:0] ry;

    vecs[0] = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 4, "multu max"};
    vecs[1] = '{3'd0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 4, "mult -3*7"};
    vecs[2] = '{3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, "div -7/2"};
    vecs[3] = '{3'd3, 32'd100, 32'd7, 32'd2, 32'd14, 33, "divu 100/7"};
    vecs[4] = '{3'd3, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1, "divu 5/0"};
    vecs[5] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 33, "div min/-1"};
    vecs[6] = '{3'd2, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 33, "div 7/-2"};
    vecs[7] = '{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0, 4, "mult min*min"};
    vecs[8] = '{3'd2, 32'h0000_0000, 32'd0, 32'd0, 32'hFFFF_FFFF, 1, "div 0/0"};

    // Reset with junk start applied: everything must come up cleared.
    rst_n = 1'b0;
    flush = 1'b0;
    start = 1'b1;
    op    = 3'd0;
    a     = $urandom;
    b     = $urandom;
    tick();
    tick();
    chk("reset hi", 64'(hi), 64'(0));
    chk("reset lo", 64'(lo), 64'(0));
    chk("reset busy", 64'(busy), 64'(0));
    chk("reset done", 64'(done), 64'(0));
    start = 1'b0;
    rst_n = 1'b1;
    tick();

    // Directed table.
    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo,
             vecs[i].lat);
      tick();
      chk({vecs[i].name, " done pulse"}, 64'(done), 64'(0));
    end

    // MTHI / MTLO / reserved.
    issue(3'd4, 32'h0000_1234, 32'hDEAD_BEEF);
    chk("mthi hi", 64'(hi), 64'h1234);
    chk("mthi busy", 64'(busy), 64'(0));
    chk("mthi done", 64'(done), 64'(0));
    issue(3'd5, 32'h0000_ABCD, 32'h0);
    chk("mtlo lo", 64'(lo), 64'hABCD);
    chk("mtlo hi kept", 64'(hi), 64'h1234);
    chk("mtlo busy", 64'(busy), 64'(0));
    issue(3'd6, 32'hDEAD_0000, 32'd3);
    chk("reserved hi", 64'(hi), 64'h1234);
    chk("reserved lo", 64'(lo), 64'hABCD);
    chk("reserved busy", 64'(busy), 64'(0));
    tick();
    chk("reserved done", 64'(done), 64'(0));

    // DIV in flight: ignored start, then flush at cycle 10.
    issue(3'd2, 32'd1000, 32'd3);
    repeat (4) tick();
    start = 1'b1;
    op    = 3'd4;
    a     = 32'h5555_5555;
    tick();
    start = 1'b0;
    chk("start while busy: busy", 64'(busy), 64'(1));
    chk("start while busy: hi", 64'(hi), 64'h1234);
    repeat (4) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush busy", 64'(busy), 64'(0));
    chk("flush done", 64'(done), 64'(0));
    chk("flush hi", 64'(hi), 64'h1234);
    chk("flush lo", 64'(lo), 64'hABCD);
    seen = 1'b0;
    repeat (40) begin
      tick();
      if (done || busy) seen = 1'b1;
    end
    chk("flush no late done", 64'(seen), 64'(0));

    // flush and start together while idle: start dropped.
    flush = 1'b1;
    start = 1'b1;
    op    = 3'd5;
    a     = 32'h7777_7777;
    tick();
    flush = 1'b0;
    start = 1'b0;
    chk("flush+start lo", 64'(lo), 64'hABCD);
    chk("flush+start busy", 64'(busy), 64'(0));

    // MULT with an MTLO attempt while busy.
    issue(3'd0, 32'd6, 32'd7);
    start = 1'b1;
    op    = 3'd5;
    a     = 32'h9999_9999;
    tick();
    start = 1'b0;
    n     = 1;
    while (!done && n < 20) begin
      tick();
      n++;
    end
    chk("mult ignore-start latency", 64'(n), 64'(MulCycles));
    chk("mult ignore-start lo", 64'(lo), 64'd42);
    chk("mult ignore-start hi", 64'(hi), 64'd0);

    // Back-to-back: issued in the done cycle of the MULT above.
    run_op("b2b divu", 3'd3, 32'd100, 32'd7, 32'd2, 32'd14, 33);

    // Reset in the middle of a MULT.
    tick();
    issue(3'd0, 32'hFFFF_FFFD, 32'd7);
    tick();
    rst_n = 1'b0;
    tick();
    chk("midreset hi", 64'(hi), 64'(0));
    chk("midreset lo", 64'(lo), 64'(0));
    chk("midreset busy", 64'(busy), 64'(0));
    chk("midreset done", 64'(done), 64'(0));
    rst_n = 1'b1;
    seen  = 1'b0;
    repeat (6) begin
      tick();
      if (done || busy) seen = 1'b1;
    end
    chk("midreset no completion", 64'(seen), 64'(0));
    run_op("after reset multu", 3'd1, 32'd6, 32'd7, 32'd0, 32'd42, int'(MulCycles));

    // Random mult/div stream, each op issued in the previous op's done cycle.
    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(3));
      rx = $urandom;
      case ($urandom_range(9))
        0:       ry = 32'd0;
        1:       ry = 32'($urandom_range(15, 1));
        2:       ry = 32'hFFFF_FFFF;
        default: ry = $urandom;
      endcase
      if ($urandom_range(3) == 0) rx = 32'($urandom_range(1000));
      model(ro, rx, ry, eh, el, lat);
      run_op($sformatf("rand%0d op%0d", i, ro), ro, rx, ry, eh, el, lat);
    end
    tick();
    chk("final done low", 64'(done), 64'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
